// File: rtl/sim_sdpram_bypass.sv
// Simple dual-port RAM model: byte-enabled write port, one read port, optional write-first bypass.
// Latency: LATENCY cycles (1..3) from ren to rvalid/rdata; stage data moves only with its valid bit.
// Backpressure: none, the read pipeline advances every cycle; rst flushes in-flight reads.
module sim_sdpram_bypass #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_ZERO = 1,
    localparam int NB       = WIDTH / 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ren,
    input  logic [AW-1:0]        raddr,
    input  logic                 wen,
    input  logic [AW-1:0]        waddr,
    input  logic [NB-1:0][7:0]   wdata,
    input  logic [NB-1:0]        wbe,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rvalid
);

    if (WIDTH % 8 != 0 || WIDTH < 8) begin : g_bad_width
        $fatal(1, "sim_sdpram_bypass: WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sim_sdpram_bypass: DEPTH must be a power of two");
    end
    if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
        $fatal(1, "sim_sdpram_bypass: LATENCY must be in 1..3");
    end

    logic [WIDTH-1:0] old_word;
    logic [WIDTH-1:0] cap_word;

    if (INIT_ZERO != 0) begin : g_mem_zero
        logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

        always_ff @(posedge clk) begin
            if (!rst && wen) begin
                for (int i = 0; i < NB; i++) begin
                    if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i];
                end
            end
        end

        assign old_word = mem[raddr];
    end else begin : g_mem_x
        logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (!rst && wen) begin
                for (int i = 0; i < NB; i++) begin
                    if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i];
                end
            end
        end

        assign old_word = mem[raddr];
    end

    // Write-first forwarding is per lane: unwritten lanes still return the old content.
    always_comb begin
        cap_word = old_word;
        if (BYPASS != 0 && wen && waddr == raddr) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) cap_word[i*8 +: 8] = wdata[i];
            end
        end
    end

    logic [LATENCY:1]  stg_vld;
    logic [WIDTH-1:0]  stg_dat [1:LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld <= '0;
            for (int k = 1; k <= LATENCY; k++) stg_dat[k] <= '0;
        end else begin
            stg_vld[1] <= ren;
            if (ren) stg_dat[1] <= cap_word;
            // Data only advances behind a valid bit, so the output holds across idle cycles.
            for (int k = 2; k <= LATENCY; k++) begin
                stg_vld[k] <= stg_vld[k-1];
                if (stg_vld[k-1]) stg_dat[k] <= stg_dat[k-1];
            end
        end
    end

    assign rvalid = stg_vld[LATENCY];
    assign rdata  = stg_dat[LATENCY];

endmodule

// File: tb/tb_sim_sdpram_bypass.sv
// Drives one stimulus stream into four RAM instances (latency 1/2/3 write-first, latency 1 read-first)
// and checks each against hand-computed values.
module tb_sim_sdpram_bypass;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren;
    logic [7:0]  raddr;
    logic        wen;
    logic [7:0]  waddr;
    logic [3:0][7:0] wdata;
    logic [3:0]  wbe;

    logic [31:0] rdata1, rdata2, rdata3, rdata0;
    logic        rvalid1, rvalid2, rvalid3, rvalid0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sim_sdpram_bypass #(.LATENCY(1), .BYPASS(1)) u_l1 (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .rdata(rdata1), .rvalid(rvalid1));
    sim_sdpram_bypass #(.LATENCY(2), .BYPASS(1)) u_l2 (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .rdata(rdata2), .rvalid(rvalid2));
    sim_sdpram_bypass #(.LATENCY(3), .BYPASS(1)) u_l3 (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .rdata(rdata3), .rvalid(rvalid3));
    sim_sdpram_bypass #(.LATENCY(1), .BYPASS(0)) u_rf (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .rdata(rdata0), .rvalid(rvalid0));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge; new inputs are applied at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ren = 1'b0; wen = 1'b0; wbe = 4'h0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wen = 1'b1; waddr = a; wdata = d; wbe = be;
    endtask

    task automatic rd(input logic [7:0] a);
        ren = 1'b1; raddr = a;
    endtask

    initial begin
        rst = 1'b1; ren = 1'b0; wen = 1'b0; raddr = '0; waddr = '0; wdata = '0; wbe = '0;
        tick(); tick();
        chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst_rdata1",  rdata1, 32'd0);
        chk("rst_rvalid3", {31'd0, rvalid3}, 32'd0);
        chk("rst_rdata3",  rdata3, 32'd0);
        rst = 1'b0;

        // Full-word write then read at each latency
        wr(8'd5, 32'hDEADBEEF, 4'hF); tick();
        idle(); rd(8'd5); tick();
        chk("t1_l1_vld",  {31'd0, rvalid1}, 32'd1);
        chk("t1_l1_dat",  rdata1, 32'hDEADBEEF);
        chk("t1_l2_early", {31'd0, rvalid2}, 32'd0);
        idle(); tick();
        chk("t1_l2_vld",  {31'd0, rvalid2}, 32'd1);
        chk("t1_l2_dat",  rdata2, 32'hDEADBEEF);
        chk("t1_l1_drop", {31'd0, rvalid1}, 32'd0);
        chk("t1_l1_hold", rdata1, 32'hDEADBEEF);
        tick();
        chk("t1_l3_vld",  {31'd0, rvalid3}, 32'd1);
        chk("t1_l3_dat",  rdata3, 32'hDEADBEEF);

        // Partial byte-lane write
        wr(8'd7, 32'h11223344, 4'hF); tick();
        wr(8'd7, 32'hAABBCCDD, 4'b0101); tick();
        idle(); rd(8'd7); tick();
        chk("t2_lanes", rdata1, 32'h11BB33DD);
        chk("t2_lanes_rf", rdata0, 32'h11BB33DD);

        // Same-cycle read/write collision
        idle(); rd(8'd3); wr(8'd3, 32'hCAFEF00D, 4'b0011); tick();
        chk("t3_bypass",    rdata1, 32'h0000F00D);
        chk("t3_readfirst", rdata0, 32'h00000000);
        chk("t3_rf_vld",    {31'd0, rvalid0}, 32'd1);
        idle(); rd(8'd3); tick();
        chk("t3_next_wf", rdata1, 32'h0000F00D);
        chk("t3_next_rf", rdata0, 32'h0000F00D);

        // Read then overwrite in the following cycle
        idle(); wr(8'd9, 32'h5, 4'hF); tick();
        idle(); rd(8'd9); tick();
        idle(); wr(8'd9, 32'h6, 4'hF); tick();
        chk("t6_l2_vld", {31'd0, rvalid2}, 32'd1);
        chk("t6_l2_dat", rdata2, 32'h5);
        idle(); tick();
        chk("t6_l3_dat", rdata3, 32'h5);
        idle(); rd(8'd9); tick();
        chk("t6_new_val", rdata1, 32'h6);
        idle(); tick(); tick(); tick();

        // Reset while reads are in flight; write under reset must be dropped
        rd(8'd5); tick();
        rd(8'd7); tick();
        rd(8'd9); rst = 1'b1; wr(8'd5, 32'h12345678, 4'hF); tick();
        chk("t4_rst_vld3", {31'd0, rvalid3}, 32'd0);
        chk("t4_rst_dat3", rdata3, 32'd0);
        chk("t4_rst_dat1", rdata1, 32'd0);
        rst = 1'b0; idle(); rd(8'd5); tick();
        chk("t4_c3_vld3", {31'd0, rvalid3}, 32'd0);
        chk("t4_c3_vld2", {31'd0, rvalid2}, 32'd0);
        chk("t4_arr_kept", rdata1, 32'hDEADBEEF);
        idle(); tick();
        chk("t4_c4_vld3", {31'd0, rvalid3}, 32'd0);
        tick();
        chk("t4_c5_vld3", {31'd0, rvalid3}, 32'd1);
        chk("t4_c5_dat3", rdata3, 32'hDEADBEEF);

        // Fill the whole array, then stream across the wrap point
        for (int i = 0; i < 256; i++) begin
            wr(i[7:0], i, 4'hF); tick();
        end
        idle(); rd(8'd255); tick();
        chk("t5_r255", rdata1, 32'd255);
        rd(8'd0); tick();
        chk("t5_r0", rdata1, 32'd0);
        chk("t5_r0_vld", {31'd0, rvalid1}, 32'd1);
        chk("t5_l2_255", rdata2, 32'd255);
        rd(8'd1); tick();
        chk("t5_r1", rdata1, 32'd1);
        chk("t5_r1_vld", {31'd0, rvalid1}, 32'd1);
        chk("t5_l2_vld", {31'd0, rvalid2}, 32'd1);
        idle(); tick();
        chk("t5_drop_vld", {31'd0, rvalid1}, 32'd0);
        chk("t5_hold", rdata1, 32'd1);
        chk("t5_l2_last", rdata2, 32'd1);
        tick();
        chk("t5_l3_last", rdata3, 32'd1);
        chk("t5_l2_hold", rdata2, 32'd1);
        chk("t5_l2_drop", {31'd0, rvalid2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
